// File: rtl/bitser_logic_unit_if.sv
// Operand/result handshake bundle for the bit-serial logic unit.
// master drives operands and accepts results; slave is the logic unit itself.
interface bitser_logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, zero, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, zero, err
  );
endinterface

// File: rtl/bitser_logic_unit.sv
// Bit-serial logic unit: one shared 1-bit slice evaluates the opcode LSB first
// over WIDTH cycles, then holds a registered result until the consumer takes it.
module bitser_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitser_logic_unit_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             calc_bit;

  // The shared 1-bit slice; the illegal opcode yields 0 so its result reads as zero.
  function automatic logic logic_bit(input logic [2:0] opc, input logic ai, input logic bi);
    logic r;
    case (opc)
      3'b000:  r = ai & bi;
      3'b001:  r = ai | bi;
      3'b010:  r = ai ^ bi;
      3'b011:  r = ~(ai & bi);
      3'b100:  r = ~(ai | bi);
      3'b101:  r = ~(ai ^ bi);
      3'b110:  r = ~ai;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state, datapath shift and result commit.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    zero_d   = zero_q;
    err_d    = err_q;
    calc_bit = logic_bit(op_q, a_sh_q[0], b_sh_q[0]);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          op_d    = bus.op;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // Result bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
        acc_d  = {calc_bit, acc_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          y_d     = acc_d;
          zero_d  = (acc_d == '0);
          err_d   = (op_q == 3'b111);
          state_d = HOLD;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = CALC;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      op_q    <= 3'b000;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Handshake strobes come from the state register only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule
